// File: rtl/pool_pkg.sv
// Shared types and helpers for the relu_pool post-convolution stage.
package pool_pkg;

    typedef enum logic [2:0] {
        EVEN_L,
        EVEN_R,
        ODD_L,
        ODD_R,
        SKIP
    } pool_state_e;

    localparam int SAT_CNT_W = 16;

    // Largest unsigned value representable in m bits.
    function automatic logic [31:0] sat_max(input int unsigned m);
        if (m >= 32)
            return '1;
        return (32'd1 << m) - 32'd1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one row of horizontally pooled pixels (both channels per word).
module pool_line_buf #(
    parameter int DEPTH = 240,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Read data is held between reads so the pooled odd-row R pixel can use it late.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/relu_pool.sv
// ReLU + requantize + saturate, then 2x2 stride-2 max pool on two channel streams.
// Optional saturation counter is built when POOL_SAT_CNT_EN is defined.
module relu_pool
    import pool_pkg::*;
#(
    parameter int M     = 8,
    parameter int W     = 480,
    parameter int H     = 480,
    parameter int SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 Rst,
    input  logic [2*M-1:0]       din1,
    input  logic [2*M-1:0]       din2,
    input  logic                 valid_in1,
    input  logic                 valid_in2,
    output logic [M-1:0]         dout1,
    output logic [M-1:0]         dout2,
    output logic                 valid_out,
    output logic                 frame_done,
    output logic                 err,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam int NCH   = 2;
    localparam int DW    = 2 * M;
    localparam int CW    = (W > 1) ? $clog2(W) : 1;
    localparam int RW    = (H > 1) ? $clog2(H) : 1;
    localparam int DEPTH = (W / 2 > 0) ? W / 2 : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit W_ODD = (W % 2) != 0;
    localparam bit H_ODD = (H % 2) != 0;
    localparam logic [DW-1:0] PIX_MAX = DW'(sat_max(M));

    pool_state_e state, state_nxt;
    logic [CW-1:0] col, ncol;
    logic [RW-1:0] row, nrow;
    logic          accept, mismatch, last_col, last_row;
    logic          wr_en, rd_en, latch_left, emit;
    logic [AW-1:0] pair_addr;

    logic [NCH-1:0][DW-1:0] din_v;
    logic [NCH-1:0][M-1:0]  pix, left_q, wr_word, rd_word, pool_max, dout_q;

    function automatic logic [M-1:0] max2(input logic [M-1:0] a, input logic [M-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Position classifier: trailing odd column/row pixels are consumed without output.
    function automatic pool_state_e pos_state(input logic [CW-1:0] c, input logic [RW-1:0] r);
        if ((W_ODD && c == CW'(W - 1)) || (H_ODD && r == RW'(H - 1)))
            return SKIP;
        if (!r[0])
            return c[0] ? EVEN_R : EVEN_L;
        return c[0] ? ODD_R : ODD_L;
    endfunction

    assign accept   = valid_in1 & valid_in2;
    assign mismatch = valid_in1 ^ valid_in2;
    assign din_v    = {din2, din1};

`ifdef POOL_SAT_CNT_EN
    logic [NCH-1:0] sat;
`endif

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [DW-1:0] relu_v, shd;
        logic          ovf;

        assign relu_v       = din_v[ch][DW-1] ? '0 : din_v[ch];
        assign shd          = relu_v >> SHIFT;
        assign ovf          = shd > PIX_MAX;
        assign pix[ch]      = ovf ? PIX_MAX[M-1:0] : shd[M-1:0];
        assign wr_word[ch]  = max2(left_q[ch], pix[ch]);
        assign pool_max[ch] = max2(max2(rd_word[ch], left_q[ch]), pix[ch]);
`ifdef POOL_SAT_CNT_EN
        assign sat[ch] = ovf;
`endif
    end

    assign last_col  = (col == CW'(W - 1));
    assign last_row  = (row == RW'(H - 1));
    assign ncol      = last_col ? '0 : col + 1'b1;
    assign nrow      = last_col ? (last_row ? '0 : row + 1'b1) : row;
    assign pair_addr = AW'(col >> 1);

    always_comb begin
        state_nxt  = state;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        latch_left = 1'b0;
        emit       = 1'b0;
        if (accept) begin
            state_nxt = pos_state(ncol, nrow);
            case (state)
                EVEN_L: latch_left = 1'b1;
                EVEN_R: wr_en      = 1'b1;
                ODD_L: begin
                    rd_en      = 1'b1;
                    latch_left = 1'b1;
                end
                ODD_R:  emit       = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state      <= EVEN_L;
            col        <= '0;
            row        <= '0;
            left_q     <= '0;
            dout_q     <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            valid_out  <= emit;
            frame_done <= accept && last_col && last_row;
            if (mismatch)
                err <= 1'b1;
            if (accept) begin
                col <= ncol;
                row <= nrow;
            end
            if (latch_left)
                left_q <= pix;
            if (emit)
                dout_q <= pool_max;
        end
    end

    assign dout1 = dout_q[0];
    assign dout2 = dout_q[1];

    pool_line_buf #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (NCH * M)
    ) u_line_buf (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(pair_addr),
        .wr_data(wr_word),
        .rd_en  (rd_en),
        .rd_addr(pair_addr),
        .rd_data(rd_word)
    );

`ifdef POOL_SAT_CNT_EN
    logic [SAT_CNT_W-1:0] sat_cnt_q;

    always_ff @(posedge clk) begin
        if (Rst)
            sat_cnt_q <= '0;
        else if (accept && (|sat) && (sat_cnt_q != '1))
            sat_cnt_q <= sat_cnt_q + 1'b1;
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = '0;
`endif

endmodule

// File: doc/relu_pool.md
# relu_pool

Post-convolution stage of the accelerator datapath. It consumes the two signed 2M-bit channel streams produced by the convolution block, one pixel per valid cycle in raster order. Each pixel goes through ReLU, an arithmetic right-shift requantization and unsigned saturation to M bits. A 2x2 stride-2 max pool then produces one pooled M-bit pixel per channel for every 2x2 input window, ready for the next layer's feature-map buffer.

## Interface
Parameters:
- M, 8, output data width; inputs are 2M bits signed.
- W, 480, input row width in pixels (convolution output width).
- H, 480, input rows per frame.
- SHIFT, 4, requantization right-shift amount, 0..2M-1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- Rst  input  1  synchronous, active-high reset.
- din1  input  2M  channel-1 pixel, signed two's complement.
- din2  input  2M  channel-2 pixel, signed.
- valid_in1  input  1  din1 valid.
- valid_in2  input  1  din2 valid.
- dout1  output  M  pooled channel-1 pixel, unsigned.
- dout2  output  M  pooled channel-2 pixel, unsigned.
- valid_out  output  1  dout1/dout2 valid, one-cycle pulse per pooled pixel.
- frame_done  output  1  one-cycle pulse after the last input pixel of a frame is accepted.
- err  output  1  sticky; set on a valid_in1/valid_in2 mismatch.
- sat_count  output  16  count of saturating input cycles; see Configuration.

## Operation
- Accept: a pixel pair is accepted only when valid_in1 && valid_in2.
  - If exactly one valid is high: the cycle is ignored, counters do not advance, and err is set.
  - err clears only on Rst.
- Per-pixel transform, applied to each channel independently:
  - ReLU: a negative value becomes 0.
  - Requantize: apply >>> SHIFT.
  - Saturate: any result greater than 2^M-1 becomes 2^M-1.
- Counters:
  - col runs 0..W-1.
  - row runs 0..H-1.
  - Both advance per accepted pixel. col wraps to 0 at W-1, and row increments at that point.
  - At (W-1, H-1) both wrap to 0 and frame_done pulses.
- FSM states:
  - EVEN_L, EVEN_R: even row, left/right column of a pair.
  - ODD_L, ODD_R: odd row, left/right column of a pair.
  - SKIP: trailing odd column or trailing odd row.
- Transitions on accept:
  - L moves to R.
  - R moves to L of the same row parity.
  - At the end of a row, go to the opposite parity's L, or to SKIP when the next column or row is a trailing odd one.
  - SKIP consumes pixels without output and leaves at the row or frame boundary.
- Even rows:
  - Latch the left pixel.
  - At R, write max(left, right) per channel into the line buffer at address col>>1.
- Odd rows:
  - At L, issue the line-buffer read at col>>1 and latch the left pixel.
  - At R, compute max(buffer, left, right) per channel and register it into dout1/dout2 with valid_out.
- Odd W: the last column of every row is dropped. Odd H: the last row is dropped.
- Output count per frame is exactly (W/2)*(H/2) valid_out pulses.
- Input stalls (no accept) between any two pixels are legal and do not alter results.

## Timing
- Reset values: dout1=0, dout2=0, valid_out=0, frame_done=0, err=0, sat_count=0. FSM goes to EVEN_L and col=row=0.
- The line buffer is not cleared by reset; its contents are always written before being read.
- Rst mid-frame abandons the frame; the next accepted pixel is treated as (0,0).
- Latency: valid_out rises 1 cycle after the accept of an ODD_R pixel.
- frame_done is registered and rises 1 cycle after the last accept. It coincides with the final valid_out when W and H are even.
- Line-buffer read is synchronous, issued at ODD_L. Data must be valid by the ODD_R accept even when ODD_R is accepted back-to-back.
- Throughput is one pixel pair per cycle with no backpressure; the block never stalls upstream.

## Configuration
- POOL_SAT_CNT_EN defined:
  - sat_count increments by 1 on every accepted cycle where either channel saturated in the requantize step.
  - It holds at 16'hFFFF and clears on Rst.
- POOL_SAT_CNT_EN undefined: sat_count is tied to 0 and no counter logic is built.

## Structure
- Shared package pool_pkg holds:
  - the FSM state enum (EVEN_L, EVEN_R, ODD_L, ODD_R, SKIP);
  - the sat_count width constant (16);
  - the saturation-max helper function.
- One sub-module, pool_line_buf: simple dual-port RAM with a W/2 x 2M data word (both channels) and synchronous read.

## Test plan
- Reset: hold Rst 3 cycles mid-stream -> all outputs 0, FSM at EVEN_L; next pixels are treated as (0,0).
- Basic pool: W=4, H=2, SHIFT=0; din1 row0 = 1,5,3,2 and row1 = 4,0,7,-9; din2 = din1+10 -> dout1 = 5 then 7, dout2 = 15 then 17, exactly 2 valid_out pulses, frame_done once.
- ReLU/saturation: SHIFT=4; din1=-100 everywhere -> dout1=0. din2=16'h1000 everywhere -> dout2=255, and sat_count = 8 with POOL_SAT_CNT_EN (0 without).
- Stalls: repeat the basic pool case with 0–3 random idle cycles between accepts -> identical outputs and pulse count.
- Odd sizes: W=5, H=3 -> exactly 2 pooled pixels; column 4 and row 2 produce no output; frame_done after the 15th accept.
- Mismatch: valid_in1=1, valid_in2=0 for one cycle mid-row -> err=1 and stays set, the pixel is not counted, and the following outputs are unchanged.
